ipc_msg_parser: RTL and testbench

- Consumes the token FIFO filled by the IPC fetch stage; pops tokens through its show-ahead-free (std, read latency 1) read port.
- Splits the token stream into commands of one header token plus N parameter tokens.
- Presents each command to the IPC command handler over a valid/ready handshake.
- A run ends at an all-zero header token or when the token budget is exhausted.

---
 rtl/ipc_msg_parser.sv | 184 ++++++++++++++++++
 tb/tb_ipc_msg_parser.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipc_msg_parser.sv
// Splits the IPC token FIFO stream into header+parameter commands for the command handler.
// Latency: three cycles per token (pop, FIFO read latency, sample); a command is offered the cycle after its last token is sampled.
// Backpressure: holds a command while CMD_READY is low and stops popping; waits in S_POP while FIFO_EMPTY is high.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   START / IDLE        run start pulse / idle indication
//   FIFO_EMPTY, FIFO_DATA, FIFO_RD_EN
//                       token FIFO read port; read latency is one cycle
//   CMD_VALID, CMD_READY, CMD_OPCODE, CMD_NPARAM, CMD_PARAMS
//                       command handshake toward the handler
//   ERR_STRB            one-cycle pulse per malformed or truncated command
//   MSG_COUNT           commands accepted in the current run, saturating
module ipc_msg_parser #(
    parameter int TOKEN_WIDTH = 32,
    parameter int MAX_PARAMS  = 8,
    parameter int MAX_TOKENS  = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              START,
    output logic                              IDLE,
    input  logic                              FIFO_EMPTY,
    input  logic [TOKEN_WIDTH-1:0]            FIFO_DATA,
    output logic                              FIFO_RD_EN,
    output logic                              CMD_VALID,
    input  logic                              CMD_READY,
    output logic [7:0]                        CMD_OPCODE,
    output logic [7:0]                        CMD_NPARAM,
    output logic [MAX_PARAMS*TOKEN_WIDTH-1:0] CMD_PARAMS,
    output logic                              ERR_STRB,
    output logic [7:0]                        MSG_COUNT
);

    localparam int CW = $clog2(MAX_TOKENS + 1);
    localparam logic [7:0]    MAXP8   = 8'(MAX_PARAMS);
    localparam logic [CW-1:0] BUDGET  = CW'(MAX_TOKENS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_HDR,
        S_PARAM,
        S_EMIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] pop_cnt;
    logic [7:0]    param_idx;
    logic          want_hdr;   // next sampled token is a header
    logic          discard;    // consuming the parameters of an oversized command
    logic          err_set;

    logic          budget_hit;
    logic          hdr_zero;
    logic [7:0]    hdr_op;
    logic [7:0]    hdr_n;
    logic          last_param;

    assign budget_hit = (pop_cnt == BUDGET);
    assign hdr_zero   = (FIFO_DATA == '0);
    assign hdr_op     = FIFO_DATA[TOKEN_WIDTH-1 -: 8];
    assign hdr_n      = FIFO_DATA[TOKEN_WIDTH-9 -: 8];
    assign last_param = (({1'b0, param_idx} + 9'd1) == {1'b0, CMD_NPARAM});

    assign IDLE      = (state == S_IDLE) && !START;
    assign CMD_VALID = (state == S_EMIT);

    always_comb begin
        state_nxt  = state;
        FIFO_RD_EN = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                // Budget exhausted: a missing header just ends the run, missing
                // parameters mean the command in flight is truncated.
                if (budget_hit) begin
                    state_nxt = S_IDLE;
                    err_set   = !want_hdr;
                end else if (!FIFO_EMPTY) begin
                    FIFO_RD_EN = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = want_hdr ? S_HDR : S_PARAM;
            end
            S_HDR: begin
                if (hdr_zero) begin
                    state_nxt = S_IDLE;
                end else if (hdr_n == 8'd0) begin
                    state_nxt = S_EMIT;
                end else begin
                    err_set   = (hdr_n > MAXP8);
                    state_nxt = S_POP;
                end
            end
            S_PARAM: begin
                if (last_param && !discard) begin
                    state_nxt = S_EMIT;
                end else begin
                    state_nxt = S_POP;
                end
            end
            S_EMIT: begin
                if (CMD_READY) begin
                    state_nxt = S_POP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pop_cnt    <= '0;
            param_idx  <= '0;
            want_hdr   <= 1'b1;
            discard    <= 1'b0;
            CMD_OPCODE <= '0;
            CMD_NPARAM <= '0;
            CMD_PARAMS <= '0;
            ERR_STRB   <= 1'b0;
            MSG_COUNT  <= '0;
        end else begin
            state    <= state_nxt;
            ERR_STRB <= err_set;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pop_cnt   <= '0;
                        MSG_COUNT <= '0;
                        want_hdr  <= 1'b1;
                        discard   <= 1'b0;
                    end
                end
                S_POP: begin
                    if (FIFO_RD_EN) begin
                        pop_cnt <= pop_cnt + CW'(1);
                    end
                end
                S_HDR: begin
                    if (!hdr_zero) begin
                        CMD_OPCODE <= hdr_op;
                        CMD_NPARAM <= hdr_n;
                        CMD_PARAMS <= '0;
                        param_idx  <= '0;
                        want_hdr   <= (hdr_n == 8'd0);
                        discard    <= (hdr_n > MAXP8);
                    end
                end
                S_PARAM: begin
                    if (!discard) begin
                        for (int i = 0; i < MAX_PARAMS; i++) begin
                            if (param_idx == 8'(i)) begin
                                CMD_PARAMS[i*TOKEN_WIDTH +: TOKEN_WIDTH] <= FIFO_DATA;
                            end
                        end
                    end
                    param_idx <= param_idx + 8'd1;
                    if (last_param) begin
                        want_hdr <= 1'b1;
                        discard  <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (CMD_READY && (MSG_COUNT != 8'hFF)) begin
                        MSG_COUNT <= MSG_COUNT + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ipc_msg_parser.sv
module tb_ipc_msg_parser;

    localparam int TW = 32;
    localparam int MP = 8;
    localparam int MT = 64;
    localparam int PW = MP * TW;

    logic          clk = 1'b0;
    logic          reset;
    logic          START;
    logic          IDLE;
    logic          FIFO_EMPTY;
    logic [TW-1:0] FIFO_DATA;
    logic          FIFO_RD_EN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [7:0]    CMD_OPCODE;
    logic [7:0]    CMD_NPARAM;
    logic [PW-1:0] CMD_PARAMS;
    logic          ERR_STRB;
    logic [7:0]    MSG_COUNT;

    always #5 clk = ~clk;

    ipc_msg_parser #(.TOKEN_WIDTH(TW), .MAX_PARAMS(MP), .MAX_TOKENS(MT)) dut (
        .clk        (clk),
        .reset      (reset),
        .START      (START),
        .IDLE       (IDLE),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_RD_EN (FIFO_RD_EN),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_OPCODE (CMD_OPCODE),
        .CMD_NPARAM (CMD_NPARAM),
        .CMD_PARAMS (CMD_PARAMS),
        .ERR_STRB   (ERR_STRB),
        .MSG_COUNT  (MSG_COUNT)
    );

    typedef struct {
        logic [7:0]    op;
        logic [7:0]    n;
        logic [PW-1:0] p;
    } cmd_t;

    cmd_t          exp_q[$];
    logic [31:0]   fifo_q[$];
    int            n_pass = 0;
    int            n_chk  = 0;
    int            obs_err = 0;
    int            obs_pops = 0;
    bit            pending_pop = 0;
    bit            rand_empty = 0;
    int            ready_pct = 100;
    bit            hold_prev = 0;
    logic [7:0]    h_op;
    logic [7:0]    h_n;
    logic [PW-1:0] h_p;

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_wide(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: walk the token list by the command rules and the pop budget,
    // producing the command list, error count and number of tokens consumed.
    task automatic model(input logic [31:0] toks[$], output int ncmd, output int nerr, output int npops);
        int          i;
        int          n;
        bit          trunc;
        logic [31:0] h;
        cmd_t        c;
        i = 0; ncmd = 0; nerr = 0; npops = 0;
        while (npops < MT) begin
            h = toks[i]; i++; npops++;
            if (h == 32'd0) break;
            n     = int'(h[23:16]);
            c.op  = h[31:24];
            c.n   = h[23:16];
            c.p   = '0;
            trunc = 0;
            for (int k = 0; k < n; k++) begin
                if (npops == MT) begin
                    trunc = 1;
                    break;
                end
                if (n <= MP) c.p[k*TW +: TW] = toks[i];
                i++; npops++;
            end
            if (n > MP) nerr++;
            if (trunc) nerr++;
            else if (n <= MP) begin
                exp_q.push_back(c);
                ncmd++;
            end
        end
    endtask

    // Compare process: outputs are sampled on the falling edge, where the
    // inputs applied after the previous rising edge are stable.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            pending_pop = 0;
            if (!reset) begin
                if (FIFO_RD_EN) begin
                    check_int("rd_en_while_empty", int'(FIFO_EMPTY), 0);
                    obs_pops++;
                    pending_pop = 1;
                end
                if (ERR_STRB) obs_err++;
                if (hold_prev && CMD_VALID) begin
                    check_int("hold_opcode", int'(CMD_OPCODE), int'(h_op));
                    check_int("hold_nparam", int'(CMD_NPARAM), int'(h_n));
                    check_wide("hold_params", CMD_PARAMS, h_p);
                end
                if (CMD_VALID && CMD_READY) begin
                    if (exp_q.size() == 0) begin
                        check_int("unexpected_cmd_opcode", int'(CMD_OPCODE), -1);
                    end else begin
                        c = exp_q.pop_front();
                        check_int("cmd_opcode", int'(CMD_OPCODE), int'(c.op));
                        check_int("cmd_nparam", int'(CMD_NPARAM), int'(c.n));
                        check_wide("cmd_params", CMD_PARAMS, c.p);
                    end
                end
                hold_prev = CMD_VALID && !CMD_READY;
                h_op = CMD_OPCODE;
                h_n  = CMD_NPARAM;
                h_p  = CMD_PARAMS;
            end else begin
                hold_prev = 0;
            end
        end
    end

    // One clock: after the rising edge, deliver a popped token and drive inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pending_pop) FIFO_DATA = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'd0;
        FIFO_EMPTY = (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
        CMD_READY  = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic run(input logic [31:0] toks[$], input bit re, input int rp, input string tag,
                       output int ncmd, output int nerr, output int npops);
        int cyc;
        exp_q.delete();
        model(toks, ncmd, nerr, npops);
        fifo_q     = toks;
        rand_empty = re;
        ready_pct  = rp;
        obs_err    = 0;
        obs_pops   = 0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 0;
        while (!IDLE && cyc < 5000) begin
            tick();
            cyc++;
        end
        check_int({tag, "_finished"}, int'(cyc < 5000), 1);
        tick();
        tick();
        check_int({tag, "_msg_count"}, int'(MSG_COUNT), (ncmd > 255) ? 255 : ncmd);
        check_int({tag, "_err_pulses"}, obs_err, nerr);
        check_int({tag, "_pops"}, obs_pops, npops);
        check_int({tag, "_cmds_left"}, exp_q.size(), 0);
        check_int({tag, "_idle"}, int'(IDLE), 1);
    endtask

    initial begin
        logic [31:0] t[$];
        int          nc, ne, np, p0, cyc;
        logic [7:0]  op8, n8;
        int          n;

        reset = 1'b1; START = 1'b0; CMD_READY = 1'b0; FIFO_EMPTY = 1'b1; FIFO_DATA = '0;
        tick(); tick(); tick();
        check_int("rst_rd_en", int'(FIFO_RD_EN), 0);
        check_int("rst_cmd_valid", int'(CMD_VALID), 0);
        check_int("rst_err", int'(ERR_STRB), 0);
        check_int("rst_msg_count", int'(MSG_COUNT), 0);
        check_int("rst_opcode", int'(CMD_OPCODE), 0);
        check_int("rst_nparam", int'(CMD_NPARAM), 0);
        check_wide("rst_params", CMD_PARAMS, '0);
        check_int("rst_idle", int'(IDLE), 1);
        reset = 1'b0;
        tick();

        // Basic two-parameter command, with literal pins on the model.
        t = '{32'h01020000, 32'hAAAA0001, 32'hBBBB0002, 32'h00000000};
        exp_q.delete();
        model(t, nc, ne, np);
        check_int("model_t1_ncmd", nc, 1);
        check_int("model_t1_pops", np, 4);
        check_int("model_t1_p0", int'(exp_q[0].p[31:0]), 32'hAAAA0001);
        check_int("model_t1_p1", int'(exp_q[0].p[63:32]), 32'hBBBB0002);
        run(t, 0, 100, "t1", nc, ne, np);

        // Zero-parameter command.
        t = '{32'h05000000, 32'h00000000};
        run(t, 0, 100, "t2", nc, ne, np);
        check_int("t2_ncmd", nc, 1);

        // Oversized command is discarded with one error, next command delivered.
        t = '{32'h07090000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9,
              32'h08010000, 32'h12345678, 32'h0};
        exp_q.delete();
        model(t, nc, ne, np);
        check_int("model_t3_err", ne, 1);
        check_int("model_t3_p0", int'(exp_q[0].p[31:0]), 32'h12345678);
        run(t, 0, 100, "t3", nc, ne, np);

        // Zero-valued parameter with FIFO_EMPTY toggling.
        t = '{32'h03010000, 32'h00000000, 32'h00000000};
        run(t, 1, 100, "t4", nc, ne, np);
        check_int("t4_ncmd", nc, 1);

        // Budget: sixteen 4-token commands and no terminator.
        t.delete();
        for (int k = 0; k < 16; k++) begin
            t.push_back(32'h01030000 | k);
            for (int j = 0; j < 3; j++) t.push_back($urandom);
        end
        run(t, 0, 70, "t5a", nc, ne, np);
        check_int("model_t5a_ncmd", nc, 16);
        check_int("model_t5a_pops", np, 64);

        // Budget: N=3 header lands on token 63, so parameters are truncated.
        t.delete();
        for (int k = 0; k < 15; k++) begin
            t.push_back(32'h01030000 | k);
            for (int j = 0; j < 3; j++) t.push_back($urandom);
        end
        t.push_back(32'h02010000); t.push_back(32'hCAFE0000);
        t.push_back(32'h09030000);
        for (int j = 0; j < 3; j++) t.push_back(32'h55);
        run(t, 0, 100, "t5b", nc, ne, np);
        check_int("model_t5b_err", ne, 1);
        check_int("model_t5b_ncmd", nc, 16);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            t.delete();
            for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
                n   = int'($urandom_range(0, 10));
                op8 = 8'($urandom_range(1, 255));
                n8  = 8'(n);
                t.push_back({op8, n8, 16'($urandom)});
                for (int j = 0; j < n; j++) t.push_back(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
            t.push_back(32'd0);
            run(t, 1'($urandom_range(0, 1)), int'($urandom_range(30, 100)), "rand", nc, ne, np);
        end

        // Held command, then reset mid-run.
        t = '{32'h02010000, 32'h00000011, 32'h00000000};
        exp_q.delete();
        model(t, nc, ne, np);
        fifo_q = t; rand_empty = 0; ready_pct = 0; obs_pops = 0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 0;
        while (!CMD_VALID && cyc < 200) begin
            tick();
            cyc++;
        end
        check_int("t6_reached_emit", int'(cyc < 200), 1);
        p0 = obs_pops;
        repeat (20) tick();
        check_int("t6_no_pops_while_held", obs_pops, p0);
        check_int("t6_still_valid", int'(CMD_VALID), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_int("t6_valid_after_reset", int'(CMD_VALID), 0);
        check_int("t6_idle_after_reset", int'(IDLE), 1);
        check_int("t6_msg_count_after_reset", int'(MSG_COUNT), 0);
        exp_q.delete();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
